// File: rtl/seq_detector_param.sv
// Run-time programmable serial pattern detector: matches a qualified bit stream
// against a loaded 1..PAT_W-bit pattern, pulsing out and counting matches.
module seq_detector_param #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             valid_in,
  input  logic             i,
  output logic             out,
  output logic [CNT_W-1:0] match_count,
  output logic             configured,
  output logic             cfg_err
);

  typedef enum logic {UNCONF, RUN} state_t;

  state_t           state, state_n;
  logic [PAT_W-1:0] hist, hist_n, hist_sh;
  logic [PAT_W-1:0] pat, pat_n, mask;
  logic [LEN_W-1:0] len, len_n, fill, fill_n, fill_inc;
  logic             ovl, ovl_n;
  logic [CNT_W-1:0] cnt_n;
  logic             out_n, err_n, hit, len_ok;

  always_comb begin
    len_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
    hist_sh  = {hist[PAT_W-2:0], i};
    fill_inc = (fill == len) ? len : fill + LEN_W'(1);
    mask     = '0;
    for (int unsigned k = 0; k < PAT_W; k++) begin
      mask[k] = (k < 32'(len));
    end
    hit = (fill_inc == len) && ((hist_sh & mask) == (pat & mask));

    state_n = state;
    hist_n  = hist;
    fill_n  = fill;
    pat_n   = pat;
    len_n   = len;
    ovl_n   = ovl;
    cnt_n   = match_count;
    err_n   = cfg_err;
    out_n   = 1'b0;

    if (load) begin
      // Any load discards history and count; a same-cycle valid_in bit is dropped.
      hist_n = '0;
      fill_n = '0;
      cnt_n  = '0;
      if (len_ok) begin
        state_n = RUN;
        pat_n   = cfg_pattern;
        len_n   = cfg_len;
        ovl_n   = cfg_overlap;
        err_n   = 1'b0;
      end else begin
        state_n = UNCONF;
        err_n   = 1'b1;
      end
    end else if (state == RUN && valid_in) begin
      hist_n = hist_sh;
      fill_n = fill_inc;
      if (hit) begin
        out_n = 1'b1;
        cnt_n = (match_count == '1) ? match_count : match_count + CNT_W'(1);
        if (!ovl) fill_n = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= UNCONF;
      hist        <= '0;
      fill        <= '0;
      pat         <= '0;
      len         <= '0;
      ovl         <= 1'b0;
      match_count <= '0;
      out         <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      state       <= state_n;
      hist        <= hist_n;
      fill        <= fill_n;
      pat         <= pat_n;
      len         <= len_n;
      ovl         <= ovl_n;
      match_count <= cnt_n;
      out         <= out_n;
      cfg_err     <= err_n;
    end
  end

  assign configured = (state == RUN);

endmodule
